// File: rtl/stack_pkg.sv
// Shared encodings for the operand-stack controller; the control unit decodes
// against these same constants.
package stack_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_TOP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/stack_controller_if.sv
// Command/response channel between the control unit (master) and the stack
// controller (slave).
interface stack_controller_if import stack_pkg::*; #(
    parameter int DATA_W = stack_pkg::DATA_W
) ();

    // A command transfers on a rising edge where cmd_valid && cmd_ready; the
    // master holds cmd_op/cmd_wr/cmd_data stable while cmd_valid waits for
    // cmd_ready. rsp_valid is a one-cycle pulse with no back-pressure.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              cmd_wr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_wr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/stack_controller.sv
// Operand-stack sequencer: owns the stack pointer and full/empty/error state and
// drives an external single-port synchronous RAM with one-cycle read latency.
module stack_controller import stack_pkg::*; #(
    parameter int DATA_W = stack_pkg::DATA_W,
    parameter int ADDR_W = stack_pkg::ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    stack_controller_if.slave   cmd,
    input  logic                err_clear,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty,
    output logic                overflow_err,
    output logic                underflow_err,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output state_t              fsm_state
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    state_t            state, state_next;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rd_zero_q, rd_zero_next;
    logic              accept;
    logic              ovf_set, unf_set;
    logic [ADDR_W-1:0] free_addr, top_addr;

    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd.cmd_ready = (state == ST_IDLE) && !reset;
    assign cmd.rsp_valid = (state == ST_RESP);
    assign cmd.rsp_data  = rsp_data_q;
    assign fsm_state     = state;

    // Only used when guarded by !full / !empty, so truncation never matters.
    assign free_addr = count[ADDR_W-1:0];
    assign top_addr  = ADDR_W'(count - 1'b1);

    always_comb begin
        state_next   = state;
        count_next   = count;
        ram_wren     = 1'b0;
        ram_addr     = addr_q;
        ram_wdata    = wdata_q;
        rd_zero_next = rd_zero_q;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_PUSH: begin
                            if (full) begin
                                ovf_set = 1'b1;
                            end else begin
                                ram_wren   = 1'b1;
                                ram_addr   = free_addr;
                                ram_wdata  = cmd.cmd_data;
                                count_next = count + 1'b1;
                            end
                        end
                        OP_POP, OP_TOP: begin
                            if (cmd.cmd_op == OP_TOP && cmd.cmd_wr) begin
                                if (empty) begin
                                    unf_set = 1'b1;
                                end else begin
                                    ram_wren  = 1'b1;
                                    ram_addr  = top_addr;
                                    ram_wdata = cmd.cmd_data;
                                end
                            end else if (empty) begin
                                // Empty reads still complete so the requester never stalls.
                                unf_set      = 1'b1;
                                rd_zero_next = 1'b1;
                                state_next   = ST_READ;
                            end else begin
                                ram_addr     = top_addr;
                                rd_zero_next = 1'b0;
                                state_next   = ST_READ;
                                if (cmd.cmd_op == OP_POP) begin
                                    count_next = count - 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_READ: state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_zero_q     <= 1'b0;
            rsp_data_q    <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            full          <= (count_next == FULL_COUNT);
            empty         <= (count_next == '0);
            addr_q        <= ram_addr;
            wdata_q       <= ram_wdata;
            rd_zero_q     <= rd_zero_next;
            if (state == ST_READ) begin
                rsp_data_q <= rd_zero_q ? '0 : ram_rdata;
            end
            // A new error event beats a simultaneous clear.
            overflow_err  <= ovf_set | (overflow_err  & ~err_clear);
            underflow_err <= unf_set | (underflow_err & ~err_clear);
        end
    end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequencing controller for the processor's operand stack. Owns the stack pointer and full/empty state, and turns push/pop/peek/replace commands from the control unit into cycle-exact accesses on an external single-port synchronous RAM. It sits between the control unit and the stack RAM, so the control unit no longer drives stack RAM address, write-enable or clock phases directly.

## Interface
- DATA_W, 16, stack word width
- ADDR_W, 5, stack RAM address width
- DEPTH, 2**ADDR_W (32), number of stack entries; must equal 2**ADDR_W
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command this cycle
- cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 PEEK/REPLACE (selected by cmd_wr)
- cmd_wr  in  1  with op 11: 1 = REPLACE top, 0 = PEEK top; ignored otherwise
- cmd_data  in  DATA_W  push/replace data
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  DATA_W  popped/peeked word
- count  out  ADDR_W+1  current number of entries (0..DEPTH)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow_err  out  1  sticky, PUSH attempted while full
- underflow_err  out  1  sticky, POP/PEEK/REPLACE attempted while empty
- err_clear  in  1  clears both sticky flags
- ram_addr  out  ADDR_W  stack RAM address
- ram_wren  out  1  stack RAM write enable
- ram_wdata  out  DATA_W  stack RAM write data
- ram_rdata  in  DATA_W  stack RAM read data; valid the cycle after the address edge

## Operation
- sp = count. Top of stack is at address sp-1; the next free slot is at sp.
- States: IDLE, READ, RESP. cmd_ready = (state == IDLE) && !reset.
- A command is accepted on an edge where cmd_valid && cmd_ready.
- NOP: accepted, no effect, stays in IDLE.
- PUSH, not full: in the accept cycle ram_addr = sp, ram_wren = 1, ram_wdata = cmd_data. sp increments at the edge. Stays in IDLE.
- REPLACE, not empty: in the accept cycle ram_addr = sp-1, ram_wren = 1. sp is unchanged. Stays in IDLE. No response.
- POP, not empty: ram_addr = sp-1, ram_wren = 0, sp decrements at the edge, then go to READ.
- PEEK, not empty: same as POP but sp is unchanged.
- READ: rsp_data is loaded from ram_rdata at the edge, then go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- PUSH while full: accepted, no RAM write, sp unchanged, overflow_err set.
- REPLACE while empty: accepted, no write, underflow_err set.
- POP/PEEK while empty: accepted, ram_wren = 0, sp unchanged, underflow_err set. Still goes through READ and RESP; rsp_data = 0 and rsp_valid pulses with normal latency, so the requester never hangs.
- err_clear and a new error event in the same cycle: set wins.
- When not in an accepting cycle, ram_wren = 0 and ram_addr holds its last value.

## Timing
- Reset values: state IDLE, count 0, empty 1, full 0, rsp_valid 0, rsp_data 0, overflow_err 0, underflow_err 0, ram_wren 0, ram_addr 0, ram_wdata 0. cmd_ready is 0 while reset is high and 1 in the first cycle after.
- PUSH/REPLACE/NOP: one-cycle throughput; count updates on the accept edge.
- POP/PEEK: accepted at edge k, rsp_data registered at edge k+1, rsp_valid high in the cycle after edge k+1. Throughput is one command per 3 cycles.
- full, empty and count are registered and reflect the state after the accept edge.
- Reset during READ or RESP: the transaction is abandoned, no rsp_valid pulse, count returns to 0.
- Addresses never wrap: accesses are guarded by full/empty, so sp-1 is never evaluated when sp = 0.

## Structure
- Shared package stack_pkg holds: the op encoding constants (OP_NOP, OP_PUSH, OP_POP, OP_TOP), the state encoding (ST_IDLE, ST_READ, ST_RESP) and the DATA_W/ADDR_W defaults, so the control unit decodes against the same constants.
- Single module with no sub-module. The stack RAM stays external as the existing single-port synchronous RAM instance.

## Test plan
- Reset, then PUSH 0x0011, 0x0022, 0x0033 back-to-back -> ram writes at addresses 0, 1, 2; count = 3; cmd_ready high every cycle.
- From that state POP, then PEEK -> first rsp_data = 0x0033 two edges after accept, count 2; PEEK returns 0x0022, count stays 2.
- REPLACE 0x00AA, then POP -> write at address 1, no rsp_valid; POP returns 0x00AA, count 1.
- Push 32 words -> full = 1. A 33rd PUSH -> no ram_wren, overflow_err = 1, count 32. err_clear -> flag cleared.
- POP on an empty stack -> underflow_err = 1, rsp_valid pulses with 0x0000, count stays 0. err_clear asserted in the same cycle as a new underflow -> flag stays 1.
- Reset asserted in the READ state of a POP -> no rsp_valid, count 0, cmd_ready 1 the cycle after reset is released.
